// File: rtl/univ_shift_reg_burst.sv
// Universal shift register with an autonomous burst engine (start/count, busy/done, abort).
// Optional feature macro: USR_ROTATE_EN enables the rotl/rotr modes (hold/zero-count burst when undefined).
module univ_shift_reg_burst #(
  parameter int DW = 8,
  parameter int SW = 1,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic [2:0]    mode,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          abort,
  input  logic [DW-1:0] data,
  input  logic [SW-1:0] data_l,
  input  logic [SW-1:0] data_h,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [2:0]    op_r, op_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [DW-1:0] q_r, q_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  // Next value of the register for one step of the given op.
  function automatic logic [DW-1:0] apply_op(input logic [2:0] op, input logic [DW-1:0] cur,
                                             input logic [DW-1:0] ld, input logic [SW-1:0] dl,
                                             input logic [SW-1:0] dh);
    logic [DW-1:0] res;
    case (op)
      M_LOAD: res = ld;
      M_SHL:  res = {cur[DW-SW-1:0], dl};
      M_SHR:  res = {dh, cur[DW-1:SW]};
`ifdef USR_ROTATE_EN
      M_ROTL: res = {cur[DW-SW-1:0], cur[DW-1:DW-SW]};
      M_ROTR: res = {cur[SW-1:0], cur[DW-1:SW]};
`endif
      M_ASR:  res = {{SW{cur[DW-1]}}, cur[DW-1:SW]};
      default: res = cur;
    endcase
    return res;
  endfunction

  // Shift modes that may run as a burst; disabled rotates fall back to a zero-count request.
  function automatic logic is_burst_op(input logic [2:0] op);
    logic res;
    case (op)
      M_SHL, M_SHR, M_ASR: res = 1'b1;
`ifdef USR_ROTATE_EN
      M_ROTL, M_ROTR:      res = 1'b1;
`endif
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  // Next-state and datapath decode for both states.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    cnt_s   = cnt_r;
    q_s     = q_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          if (is_burst_op(mode) && (count != {CW{1'b0}})) begin
            op_s    = mode;
            cnt_s   = count;
            busy_s  = 1'b1;
            state_s = BURST;
          end else begin
            // Zero-length shift requests leave q alone; hold/load still execute.
            if ((mode == M_HOLD) || (mode == M_LOAD) || (mode == 3'b111)) begin
              q_s = apply_op(mode, q_r, data, data_l, data_h);
            end else begin
              q_s = q_r;
            end
            done_s = 1'b1;
          end
        end else begin
          q_s = apply_op(mode, q_r, data, data_l, data_h);
        end
      end
      BURST: begin
        if (abort) begin
          busy_s  = 1'b0;
          cnt_s   = {CW{1'b0}};
          state_s = IDLE;
        end else begin
          q_s = apply_op(op_r, q_r, data, data_l, data_h);
          if (cnt_r == CW'(1)) begin
            busy_s  = 1'b0;
            done_s  = 1'b1;
            cnt_s   = {CW{1'b0}};
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r - CW'(1);
          end
        end
      end
      default: begin
        busy_s  = 1'b0;
        cnt_s   = {CW{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_r <= IDLE;
      op_r    <= 3'b000;
      cnt_r   <= {CW{1'b0}};
      q_r     <= {DW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      cnt_r   <= cnt_s;
      q_r     <= q_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign q    = q_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Directed bench for univ_shift_reg_burst: an SW=1 instance and an SW=2 instance.
module tb_univ_shift_reg_burst;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode, mode2;
  logic       start, start2, abort, abort2;
  logic [3:0] count, count2;
  logic [7:0] data, data2;
  logic       data_l, data_h;
  logic [1:0] data_l2, data_h2;
  logic [7:0] q, q2;
  logic       busy, busy2, done, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  univ_shift_reg_burst #(.DW(8), .SW(1), .CW(4)) dut (
    .clk(clk), .async_rst(rst), .mode(mode), .start(start), .count(count), .abort(abort),
    .data(data), .data_l(data_l), .data_h(data_h), .q(q), .busy(busy), .done(done));

  univ_shift_reg_burst #(.DW(8), .SW(2), .CW(4)) dut2 (
    .clk(clk), .async_rst(rst), .mode(mode2), .start(start2), .count(count2), .abort(abort2),
    .data(data2), .data_l(data_l2), .data_h(data_h2), .q(q2), .busy(busy2), .done(done2));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 3'b000; start = 1'b0; count = 4'd0; abort = 1'b0;
    data = 8'h00; data_l = 1'b0; data_h = 1'b0;
    mode2 = 3'b000; start2 = 1'b0; count2 = 4'd0; abort2 = 1'b0;
    data2 = 8'h00; data_l2 = 2'b00; data_h2 = 2'b00;
    tick(); tick();
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset q=%h busy=%b done=%b exp 00 0 0", q, busy, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_hold q=%h busy=%b done=%b exp 00 0 0", q, busy, done);
    end
  endtask

  task automatic test_shl();
    logic [7:0] exp_q [3] = '{8'h4B, 8'h97, 8'h2F};
    mode = 3'b001; data = 8'hA5;
    tick();
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL load q=%h exp a5", q); end
    mode = 3'b010; data_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || busy !== 1'b0) begin
        errors++; $display("FAIL shl_%0d q=%h busy=%b exp %h 0", i, q, busy, exp_q[i]);
      end
    end
    // shr with data_h in IDLE
    mode = 3'b011; data_h = 1'b1;
    tick();
    checks++;
    if (q !== 8'h97) begin errors++; $display("FAIL shr q=%h exp 97", q); end
    mode = 3'b000;
    tick();
    checks++;
    if (q !== 8'h97) begin errors++; $display("FAIL hold q=%h exp 97", q); end
  endtask

  task automatic test_burst_rotl();
    logic [7:0] exp_q [3] = '{8'h03, 8'h06, 8'h0C};
    mode = 3'b001; data = 8'h81;
    tick();
    mode = 3'b100; start = 1'b1; count = 4'd3;
    tick();
    start = 1'b0; mode = 3'b000; count = 4'd0;
`ifdef USR_ROTATE_EN
    checks++;
    if (q !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL rotl_start q=%h busy=%b done=%b exp 81 1 0", q, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
        errors++; $display("FAIL rotl_%0d q=%h busy=%b done=%b exp %h %b %b", i, q, busy, done,
                           exp_q[i], i < 2, i == 2);
      end
    end
`else
    checks++;
    if (q !== 8'h81 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL rotl_off q=%h busy=%b done=%b exp 81 0 1", q, busy, done);
    end
`endif
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rotl_end busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_asr_sw2();
    mode2 = 3'b001; data2 = 8'h90;
    tick();
    mode2 = 3'b110; start2 = 1'b1; count2 = 4'd2;
    tick();
    start2 = 1'b0; mode2 = 3'b000;
    checks++;
    if (q2 !== 8'h90 || busy2 !== 1'b1) begin
      errors++; $display("FAIL asr_start q=%h busy=%b exp 90 1", q2, busy2);
    end
    tick();
    checks++;
    if (q2 !== 8'hE4 || busy2 !== 1'b1 || done2 !== 1'b0) begin
      errors++; $display("FAIL asr_1 q=%h busy=%b done=%b exp e4 1 0", q2, busy2, done2);
    end
    tick();
    checks++;
    if (q2 !== 8'hF9 || busy2 !== 1'b0 || done2 !== 1'b1) begin
      errors++; $display("FAIL asr_2 q=%h busy=%b done=%b exp f9 0 1", q2, busy2, done2);
    end
    tick();
    checks++;
    if (q2 !== 8'hF9 || done2 !== 1'b0) begin
      errors++; $display("FAIL asr_end q=%h done=%b exp f9 0", q2, done2);
    end
  endtask

  task automatic test_zero_count();
    mode = 3'b001; data = 8'h3C;
    tick();
    mode = 3'b011; start = 1'b1; count = 4'd0; data_h = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    checks++;
    if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL zero_cnt q=%h busy=%b done=%b exp 3c 0 1", q, busy, done);
    end
    tick();
    checks++;
    if (q !== 8'h3C || done !== 1'b0) begin
      errors++; $display("FAIL zero_cnt_end q=%h done=%b exp 3c 0", q, done);
    end
    // start with load executes the load once and pulses done
    mode = 3'b001; start = 1'b1; count = 4'd4; data = 8'h5A;
    tick();
    start = 1'b0; mode = 3'b000;
    checks++;
    if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL start_load q=%h busy=%b done=%b exp 5a 0 1", q, busy, done);
    end
  endtask

  task automatic test_abort();
    mode = 3'b001; data = 8'h01;
    tick();
    mode = 3'b010; start = 1'b1; count = 4'd5; data_l = 1'b0;
    tick();
    start = 1'b0; mode = 3'b000;
    tick();
    checks++;
    if (q !== 8'h02 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre q=%h busy=%b exp 02 1", q, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (q !== 8'h02 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort q=%h busy=%b done=%b exp 02 0 0", q, busy, done);
    end
    tick();
    checks++;
    if (q !== 8'h02 || done !== 1'b0) begin
      errors++; $display("FAIL abort_after q=%h done=%b exp 02 0", q, done);
    end
    // abort on the final step wins: no shift, no done
    mode = 3'b010; start = 1'b1; count = 4'd1;
    tick();
    start = 1'b0; mode = 3'b000; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (q !== 8'h02 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_final q=%h busy=%b done=%b exp 02 0 0", q, busy, done);
    end
    // abort in IDLE is ignored
    mode = 3'b010; abort = 1'b1;
    tick();
    abort = 1'b0; mode = 3'b000;
    checks++;
    if (q !== 8'h04 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle q=%h busy=%b exp 04 0", q, busy);
    end
  endtask

  task automatic test_back_to_back();
    mode = 3'b010; start = 1'b1; count = 4'd2; data_l = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    tick();
    checks++;
    if (q !== 8'h09 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_1 q=%h busy=%b exp 09 1", q, busy);
    end
    tick();
    checks++;
    if (q !== 8'h13 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_2 q=%h busy=%b done=%b exp 13 0 1", q, busy, done);
    end
    mode = 3'b011; start = 1'b1; count = 4'd1; data_h = 1'b0;
    tick();
    start = 1'b0; mode = 3'b000;
    checks++;
    if (q !== 8'h13 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_start q=%h busy=%b done=%b exp 13 1 0", q, busy, done);
    end
    tick();
    checks++;
    if (q !== 8'h09 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_3 q=%h busy=%b done=%b exp 09 0 1", q, busy, done);
    end
  endtask

  task automatic test_async_rst();
    mode = 3'b010; start = 1'b1; count = 4'd5; data_l = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_rst q=%h busy=%b done=%b exp 00 0 0", q, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    mode = 3'b001; data = 8'h5A;
    tick();
    mode = 3'b100;
    tick();
    mode = 3'b000;
    checks++;
`ifdef USR_ROTATE_EN
    if (q !== 8'hB4) begin errors++; $display("FAIL rotl_idle q=%h exp b4", q); end
`else
    if (q !== 8'h5A) begin errors++; $display("FAIL rotl_idle_off q=%h exp 5a", q); end
`endif
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_rst busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_burst_rotl();
    test_asr_sw2();
    test_zero_count();
    test_abort();
    test_back_to_back();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
